// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, seven-segment table and digit-select constants
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Active-low one-hot digit selects: units, tens, hundreds
   localparam logic [2:0] AN_D0 = 3'b110;
   localparam logic [2:0] AN_D1 = 3'b101;
   localparam logic [2:0] AN_D2 = 3'b011;

   localparam logic [6:0] SEG_DASH = 7'b0111111;

   // Active-low segments {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash
   function automatic logic [6:0] bcd_to_seg(input bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade: counts 0..9 on inc, carry is combinational lookahead
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       ar,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   bcd_t r_q;

   assign carry = inc && (r_q == BCD_MAX);
   assign q     = r_q;

   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         r_q <= '0;
      end else if (inc) begin
         r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_ctr3.sv
// rtl/bcd_ctr3.sv - prescaled 3-digit saturating BCD counter; BCD_CTR3_SEG_MUX_EN adds
// a multiplexed seven-segment driver (an/seg ports)
module bcd_ctr3
   import bcd_pkg::*;
#(
   parameter int unsigned DIV      = 10000,
   parameter int unsigned SCAN_DIV = 10000
)(
   input  logic       clk,
   input  logic       ar,
   input  logic       en,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic       ovf
`ifdef BCD_CTR3_SEG_MUX_EN
   ,
   output logic [2:0] an,
   output logic [6:0] seg
`endif
);

   if (DIV < 2 || DIV > 65535 || SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_param
      $error("bcd_ctr3: DIV and SCAN_DIV must lie in 2..65535");
   end

   localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

   logic [15:0] r_pre;
   logic        r_ovf;
   logic        w_tick;
   logic        w_full;
   logic        w_inc;
   logic        w_c0;
   logic        w_c1;
   logic        w_c2;
   logic [3:0]  w_d0;
   logic [3:0]  w_d1;
   logic [3:0]  w_d2;

   assign w_tick = en && (r_pre == PRE_LAST);
   assign w_full = (w_d0 == BCD_MAX) && (w_d1 == BCD_MAX) && (w_d2 == BCD_MAX);
   // Increments are suppressed at 999 so the digits saturate instead of rolling to 000
   assign w_inc  = w_tick && !w_full;

   bcd_digit u_d0 (.clk(clk), .ar(ar), .inc(w_inc), .q(w_d0), .carry(w_c0));
   bcd_digit u_d1 (.clk(clk), .ar(ar), .inc(w_c0),  .q(w_d1), .carry(w_c1));
   bcd_digit u_d2 (.clk(clk), .ar(ar), .inc(w_c1),  .q(w_d2), .carry(w_c2));

   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         r_pre <= '0;
         r_ovf <= 1'b0;
      end else if (en) begin
         r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 16'd1;
         // A hundreds carry would mean a rollover slipped past the saturation gate
         r_ovf <= r_ovf || (w_tick && w_full) || w_c2;
      end
   end

   assign d0  = w_d0;
   assign d1  = w_d1;
   assign d2  = w_d2;
   assign ovf = r_ovf;

`ifdef BCD_CTR3_SEG_MUX_EN
   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] r_scan;
   logic [2:0]  r_an;
   logic [6:0]  r_seg;
   logic [2:0]  w_an_next;
   logic [3:0]  w_sel;

   always_comb begin
      w_an_next = r_an;
      if (r_scan == SCAN_LAST) begin
         w_an_next = {r_an[1:0], r_an[2]};
      end
      case (w_an_next)
         AN_D1:   w_sel = w_d1;
         AN_D2:   w_sel = w_d2;
         default: w_sel = w_d0;
      endcase
   end

   // Segments are decoded against the upcoming select so an and seg change together
   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         r_scan <= '0;
         r_an   <= AN_D0;
         r_seg  <= bcd_to_seg(4'd0);
      end else begin
         r_scan <= (r_scan == SCAN_LAST) ? '0 : r_scan + 16'd1;
         r_an   <= w_an_next;
         r_seg  <= r_ovf ? SEG_DASH : bcd_to_seg(w_sel);
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
`endif

endmodule

// File: tb/tb_bcd_ctr3.sv
// tb/tb_bcd_ctr3.sv - scoreboard bench for bcd_ctr3 (DIV=4, SCAN_DIV=3); covers an/seg when
// BCD_CTR3_SEG_MUX_EN is defined
module tb_bcd_ctr3;

   localparam int DIV      = 4;
   localparam int SCAN_DIV = 3;

   logic       clk = 1'b0;
   logic       ar  = 1'b0;
   logic       en  = 1'b0;
   logic [3:0] d0, d1, d2;
   logic       ovf;
`ifdef BCD_CTR3_SEG_MUX_EN
   logic [2:0] an;
   logic [6:0] seg;
`endif

   always #5 clk = ~clk;

   bcd_ctr3 #(.DIV(DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk),
      .ar(ar),
      .en(en),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .ovf(ovf)
`ifdef BCD_CTR3_SEG_MUX_EN
      ,
      .an(an),
      .seg(seg)
`endif
   );

   typedef struct {
      logic [11:0] bcd;
      logic        ovf;
      logic [2:0]  an;
      logic [6:0]  seg;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   int         m_pre, m_val, m_scan;
   logic       m_ovf;
   logic [2:0] m_an;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] seg_of(input int dg);
      case (dg)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg();
      if (m_ovf) return 7'b0111111;
      case (m_an)
         3'b101:  return seg_of((m_val / 10) % 10);
         3'b011:  return seg_of(m_val / 100);
         default: return seg_of(m_val % 10);
      endcase
   endfunction

   task automatic model_reset();
      m_pre  = 0;
      m_val  = 0;
      m_ovf  = 1'b0;
      m_scan = 0;
      m_an   = 3'b110;
      sb.delete();
   endtask

   task automatic run(input logic ev);
      en = ev;
      if (ev) begin
         if (m_pre == DIV - 1) begin
            m_pre = 0;
            if (m_val == 999) m_ovf = 1'b1;
            else m_val++;
         end else begin
            m_pre++;
         end
      end
      if (m_scan == SCAN_DIV - 1) begin
         m_scan = 0;
         m_an   = {m_an[1:0], m_an[2]};
      end else begin
         m_scan++;
      end
      sb.push_back('{to_bcd(m_val), m_ovf, m_an, exp_seg()});
      @(posedge clk);
      #1;
   endtask

   task automatic skip(input int n, input logic ev);
      repeat (n) begin
         run(ev);
         e = sb.pop_front();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      ar = 1'b0;
      #2;
      model_reset();
      ar = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b1;
      ar = 1'b0;
      #1;
      checks++;
      if ({d2, d1, d0} !== 12'h000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: got %h ovf=%b want 000 ovf=0", {d2, d1, d0}, ovf);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({d2, d1, d0} !== 12'h000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_overrides_en: got %h ovf=%b want 000 ovf=0", {d2, d1, d0}, ovf);
      end
`ifdef BCD_CTR3_SEG_MUX_EN
      checks++;
      if (an !== 3'b110 || seg !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_seg: got an=%b seg=%b want an=110 seg=1000000", an, seg);
      end
`endif
      model_reset();
      ar = 1'b1;
   endtask

   task automatic test_first_count();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run(1'b1);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd || ovf !== e.ovf) begin
            failures++;
            $display("FAIL first_count[%0d]: got %h ovf=%b want %h ovf=%b", i, {d2, d1, d0}, ovf, e.bcd, e.ovf);
         end
      end
      checks++;
      if ({d2, d1, d0} !== 12'h001) begin
         failures++;
         $display("FAIL first_count_final: got %h want 001", {d2, d1, d0});
      end
   endtask

   task automatic test_carry();
      do_reset();
      skip(36, 1'b1);
      checks++;
      if ({d2, d1, d0} !== 12'h009) begin
         failures++;
         $display("FAIL carry_pre009: got %h want 009", {d2, d1, d0});
      end
      for (int i = 0; i < 4; i++) begin
         run(1'b1);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd) begin
            failures++;
            $display("FAIL carry_units[%0d]: got %h want %h", i, {d2, d1, d0}, e.bcd);
         end
      end
      checks++;
      if ({d2, d1, d0} !== 12'h010) begin
         failures++;
         $display("FAIL carry_010: got %h want 010", {d2, d1, d0});
      end
      skip(356, 1'b1);
      checks++;
      if ({d2, d1, d0} !== 12'h099) begin
         failures++;
         $display("FAIL carry_pre099: got %h want 099", {d2, d1, d0});
      end
      for (int i = 0; i < 4; i++) begin
         run(1'b1);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd) begin
            failures++;
            $display("FAIL carry_tens[%0d]: got %h want %h", i, {d2, d1, d0}, e.bcd);
         end
      end
      checks++;
      if ({d2, d1, d0} !== 12'h100) begin
         failures++;
         $display("FAIL carry_100: got %h want 100", {d2, d1, d0});
      end
   endtask

   task automatic test_en_hold();
      logic pat [14];
      pat = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      do_reset();
      for (int i = 0; i < 14; i++) begin
         run(pat[i]);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd || ovf !== e.ovf) begin
            failures++;
            $display("FAIL en_hold[%0d]: got %h ovf=%b want %h ovf=%b", i, {d2, d1, d0}, ovf, e.bcd, e.ovf);
         end
      end
      checks++;
      if ({d2, d1, d0} !== 12'h001) begin
         failures++;
         $display("FAIL en_hold_final: got %h want 001", {d2, d1, d0});
      end
   endtask

   task automatic test_saturate();
      do_reset();
      skip(3992, 1'b1);
      checks++;
      if ({d2, d1, d0} !== 12'h998 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL sat_pre998: got %h ovf=%b want 998 ovf=0", {d2, d1, d0}, ovf);
      end
      for (int i = 0; i < 33; i++) begin
         run(i < 28);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd || ovf !== e.ovf) begin
            failures++;
            $display("FAIL saturate[%0d]: got %h ovf=%b want %h ovf=%b", i, {d2, d1, d0}, ovf, e.bcd, e.ovf);
         end
      end
      checks++;
      if ({d2, d1, d0} !== 12'h999 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL sat_final: got %h ovf=%b want 999 ovf=1", {d2, d1, d0}, ovf);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      skip(1428, 1'b1);
      checks++;
      if ({d2, d1, d0} !== 12'h357) begin
         failures++;
         $display("FAIL areset_pre357: got %h want 357", {d2, d1, d0});
      end
      en = 1'b1;
      #2;
      ar = 1'b0;
      #1;
      checks++;
      if ({d2, d1, d0} !== 12'h000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL areset_midcycle: got %h ovf=%b want 000 ovf=0", {d2, d1, d0}, ovf);
      end
      model_reset();
      @(posedge clk);
      #1;
      ar = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run(1'b1);
         e = sb.pop_front();
         checks++;
         if ({d2, d1, d0} !== e.bcd || ovf !== e.ovf) begin
            failures++;
            $display("FAIL areset_resume[%0d]: got %h ovf=%b want %h ovf=%b", i, {d2, d1, d0}, ovf, e.bcd, e.ovf);
         end
      end
   endtask

`ifdef BCD_CTR3_SEG_MUX_EN
   task automatic test_seg_mux();
      do_reset();
      skip(492, 1'b1);
      skip(1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         run(1'b0);
         e = sb.pop_front();
         checks++;
         if (an !== e.an || seg !== e.seg) begin
            failures++;
            $display("FAIL seg_123[%0d]: got an=%b seg=%b want an=%b seg=%b", i, an, seg, e.an, e.seg);
         end
      end
      do_reset();
      skip(4000, 1'b1);
      skip(1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         run(1'b0);
         e = sb.pop_front();
         checks++;
         if (an !== e.an || seg !== 7'b0111111) begin
            failures++;
            $display("FAIL seg_dash[%0d]: got an=%b seg=%b want an=%b seg=0111111", i, an, seg, e.an);
         end
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_first_count();
      test_carry();
      test_en_hold();
      test_saturate();
      test_async_reset();
`ifdef BCD_CTR3_SEG_MUX_EN
      test_seg_mux();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
